// File: rtl/CorePack.sv
// rtl/CorePack.sv - shared core types and opcode constants for the multi-cycle control path
package CorePack;

  typedef enum logic [2:0] {
    FETCH, DECODE, EXEC, MEM, WB, TRAP
  } ctrl_state_enum;

  typedef enum logic [1:0] {
    PC4, BR_TGT, JAL_TGT, JALR_TGT
  } pc_sel_enum;

  typedef enum logic [2:0] {
    IMM0, I_IMM, S_IMM, B_IMM, U_IMM, UJ_IMM
  } imm_op_enum;

  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM    = 7'b0010011;
  localparam logic [6:0] OPC_OP32     = 7'b0111011;
  localparam logic [6:0] OPC_OPIMM32  = 7'b0011011;

endpackage

// File: rtl/mc_ctrl_if.sv
// rtl/mc_ctrl_if.sv - memory handshake and datapath strobe bundle of the control sequencer
interface mc_ctrl_if;
  import CorePack::*;

  logic        imem_ack;
  logic [31:0] inst;
  logic        br_taken;
  logic        dmem_ack;
  logic        imem_req;
  logic        dmem_req;
  logic        dmem_we;
  logic        ir_we;
  logic        reg_we;
  logic        pc_we;
  pc_sel_enum  pc_sel;
  imm_op_enum  immgen_op;
  logic        trap;

  modport master (
    input  imem_ack, inst, br_taken, dmem_ack,
    output imem_req, dmem_req, dmem_we, ir_we, reg_we, pc_we, pc_sel, immgen_op, trap
  );

  modport slave (
    output imem_ack, inst, br_taken, dmem_ack,
    input  imem_req, dmem_req, dmem_we, ir_we, reg_we, pc_we, pc_sel, immgen_op, trap
  );

endinterface

// File: rtl/imm_sel_decode.sv
// rtl/imm_sel_decode.sv - opcode to immediate-format selector with legality flag
module imm_sel_decode
  import CorePack::*;
(
  input  logic [6:0] i_opcode,
  output imm_op_enum o_imm_op,
  output logic       o_legal
);

  always_comb begin
    o_imm_op = IMM0;
    o_legal  = 1'b1;
    case (i_opcode)
      OPC_OPIMM, OPC_OPIMM32, OPC_LOAD, OPC_JALR: o_imm_op = I_IMM;
      OPC_STORE:                                  o_imm_op = S_IMM;
      OPC_BRANCH:                                 o_imm_op = B_IMM;
      OPC_LUI, OPC_AUIPC:                         o_imm_op = U_IMM;
      OPC_JAL:                                    o_imm_op = UJ_IMM;
      OPC_OP, OPC_OP32:                           o_imm_op = IMM0;
      default:                                    o_legal  = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// rtl/mc_ctrl.sv - multi-cycle fetch/decode/exec/mem/writeback sequencer for the RV64I core
module mc_ctrl
  import CorePack::*;
(
  input  logic         clk,
  input  logic         rstn,
  mc_ctrl_if.master    bus
);

  ctrl_state_enum r_state;
  ctrl_state_enum w_next;
  logic [6:0]     r_opcode;
  imm_op_enum     w_imm_op;
  logic           w_legal;
  logic           w_is_load;
  logic           w_is_store;
  logic           w_is_branch;
  logic           w_unused;

  assign w_is_load   = (r_opcode == OPC_LOAD);
  assign w_is_store  = (r_opcode == OPC_STORE);
  assign w_is_branch = (r_opcode == OPC_BRANCH);
  assign w_unused    = ^bus.inst[31:7];

  imm_sel_decode u_imm_sel (
    .i_opcode (r_opcode),
    .o_imm_op (w_imm_op),
    .o_legal  (w_legal)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_opcode <= '0;
    end else if (r_state == FETCH && bus.imem_ack) begin
      r_opcode <= bus.inst[6:0];
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      FETCH:  if (bus.imem_ack) w_next = DECODE;
      DECODE: w_next = w_legal ? EXEC : TRAP;
      EXEC: begin
        if (w_is_branch)                 w_next = FETCH;
        else if (w_is_load || w_is_store) w_next = MEM;
        else                             w_next = WB;
      end
      MEM:    if (bus.dmem_ack) w_next = w_is_load ? WB : FETCH;
      WB:     w_next = FETCH;
      TRAP:   w_next = TRAP;
      default: w_next = FETCH;
    endcase
  end

  // Outputs are gated by rstn so an asserted reset forces reset values without waiting for a clock.
  always_comb begin
    bus.imem_req  = 1'b0;
    bus.dmem_req  = 1'b0;
    bus.dmem_we   = 1'b0;
    bus.ir_we     = 1'b0;
    bus.reg_we    = 1'b0;
    bus.pc_we     = 1'b0;
    bus.pc_sel    = PC4;
    bus.immgen_op = IMM0;
    bus.trap      = 1'b0;
    if (rstn) begin
      case (r_state)
        FETCH: begin
          bus.imem_req = 1'b1;
          bus.ir_we    = bus.imem_ack;
        end
        DECODE: bus.immgen_op = w_imm_op;
        EXEC: begin
          bus.immgen_op = w_imm_op;
          if (w_is_branch) begin
            bus.pc_we  = 1'b1;
            bus.pc_sel = bus.br_taken ? BR_TGT : PC4;
          end
        end
        MEM: begin
          bus.immgen_op = w_imm_op;
          bus.dmem_req  = 1'b1;
          bus.dmem_we   = w_is_store;
          bus.pc_we     = w_is_store && bus.dmem_ack;
        end
        WB: begin
          bus.immgen_op = w_imm_op;
          bus.reg_we    = 1'b1;
          bus.pc_we     = 1'b1;
          if (r_opcode == OPC_JAL)       bus.pc_sel = JAL_TGT;
          else if (r_opcode == OPC_JALR) bus.pc_sel = JALR_TGT;
        end
        TRAP: bus.trap = 1'b1;
        default: bus.trap = 1'b0;
      endcase
    end
  end

endmodule

// File: doc/mc_ctrl.md
# mc_ctrl

Multi-cycle control sequencer for the RV64I core. It steps each instruction through fetch, decode, execute, memory and writeback phases. It sequences the instruction and data memory handshakes and drives the immediate-generator opcode plus the write strobes of the shared PC, IR, register-file and memory datapath. It sits between the instruction/data memory ports and the single shared datapath (ImmGen, ALU, register file).

## Interface
Parameters: none. Types and constants come from `CorePack`.
- `clk`  in  1  core clock, all state updates on rising edge
- `rstn`  in  1  reset, asynchronous, active-low
- `imem_ack`  in  1  instruction memory has returned `inst` this cycle
- `inst`  in  32  fetched instruction, valid when `imem_ack`=1
- `br_taken`  in  1  branch comparator result from the datapath, valid in EXEC
- `dmem_ack`  in  1  data access completes this cycle
- `imem_req`  out  1  fetch request
- `dmem_req`  out  1  data access request
- `dmem_we`  out  1  data access is a store (valid with `dmem_req`)
- `ir_we`  out  1  latch `inst` into IR
- `reg_we`  out  1  register-file write strobe
- `pc_we`  out  1  PC update strobe
- `pc_sel`  out  `pc_sel_enum`  PC source: PC4, BR_TGT, JAL_TGT, JALR_TGT
- `immgen_op`  out  `imm_op_enum`  selector for ImmGen
- `trap`  out  1  illegal opcode seen (sticky)

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB, TRAP.
- FETCH:
  - Hold `imem_req`=1 until `imem_ack`.
  - In the ack cycle, pulse `ir_we`, capture `inst[6:0]` into the internal opcode register, then go to DECODE.
- DECODE:
  - `immgen_op` is driven from the registered opcode:
    - OP-IMM, OP-IMM-32, LOAD, JALR → I_IMM
    - STORE → S_IMM
    - BRANCH → B_IMM
    - LUI, AUIPC → U_IMM
    - JAL → UJ_IMM
    - OP, OP-32 → IMM0
  - Any other opcode goes to TRAP. Otherwise go to EXEC.
- EXEC:
  - BRANCH: pulse `pc_we`; `pc_sel`=BR_TGT if `br_taken`, else PC4. Go to FETCH.
  - LOAD or STORE: go to MEM.
  - All other opcodes: go to WB.
- MEM:
  - Hold `dmem_req`=1 until `dmem_ack`; `dmem_we`=1 for STORE, 0 for LOAD.
  - On ack, LOAD goes to WB.
  - On ack, STORE pulses `pc_we` with `pc_sel`=PC4 and goes to FETCH.
- WB: pulse `reg_we` and `pc_we`. `pc_sel` is JAL_TGT for JAL, JALR_TGT for JALR, otherwise PC4. Go to FETCH.
- TRAP:
  - Absorbing state; `trap`=1.
  - All requests and strobes are 0; only reset leaves it.
- `immgen_op` holds its DECODE value through the end of the instruction and returns to IMM0 in FETCH.

## Timing
- Reset values:
  - State FETCH.
  - `immgen_op`=IMM0, `pc_sel`=PC4.
  - `trap`=0.
  - All requests and strobes 0.
- `imem_req`=1 in the first cycle after `rstn` deasserts.
- Requests and `immgen_op` are functions of the registered state only. `ir_we`, `pc_we` and `reg_we` are single-cycle and ack-qualified where noted.
- Request stability: once raised, a request stays high, with `dmem_we` unchanged, until the cycle of its ack inclusive.
- Acks arriving while no request is outstanding are ignored.
- Minimum cycles per instruction, with ack in the first request cycle:
  - Branch 3
  - OP, OP-IMM, LUI, AUIPC, JAL, JALR, store 4
  - Load 5
- Each wait cycle on an ack adds one cycle.
- `rstn` asserted mid-instruction (including during a held request) returns the block to reset values immediately and asynchronously. No partial strobe is emitted.

## Structure
- `CorePack` additions:
  - `ctrl_state_enum`
  - `pc_sel_enum`
  - opcode constants OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC, OPC_OP, OPC_OPIMM, OPC_OP32, OPC_OPIMM32
- Sub-module `imm_sel_decode`: combinational opcode → {`imm_op_enum`, legal flag}. It is instanced once and shared with any later pipelined decoder.
- `mc_ctrl` holds the state register, the opcode register and the output logic.

## Test plan
- Reset, then `inst`=0x00500093 (addi x1,x0,5) with immediate ack:
  - `ir_we` in cycle 1.
  - `immgen_op`=I_IMM in cycles 2–4.
  - `reg_we` and `pc_we` (PC4) in cycle 4.
  - `imem_req` again in cycle 5.
- `inst`=0x0000A103 (lw), `dmem_ack` delayed 3 cycles:
  - `dmem_req`=1 and `dmem_we`=0, stable for 4 cycles.
  - `reg_we` in the following cycle; total 8 cycles.
- `inst`=0x00112023 (sw) with immediate ack:
  - `immgen_op`=S_IMM.
  - `dmem_we`=1.
  - `pc_we`=1 in the MEM ack cycle; 4 cycles total; `reg_we` never asserted.
- `inst`=0x00208463 (beq):
  - With `br_taken`=1: `immgen_op`=B_IMM and `pc_sel`=BR_TGT with `pc_we` in cycle 3.
  - Repeat with `br_taken`=0: `pc_sel`=PC4.
- `inst`=0x00000000 → `trap`=1 from cycle 3 onward, no further `imem_req`. `rstn` low then clears `trap` and fetch resumes.
- `rstn` pulled low while `dmem_req` is held in MEM → all outputs at reset values in the same cycle, then restart from FETCH.
